// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, FSM states,
// datapath mux codes and the control-word payload.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_J, OP_ADDI, OP_ANDI: op_legal = 1'b1;
            default:                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcc_out_decode.sv
// Moore output decode: FSM state (+opcode, +mem_ready for gated enables)
// to datapath control word. Purely combinational.
module mcc_out_decode
    import mips_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output ctrl_t           ctrl_c
);

    // Per-state control word; everything not named in a state stays 0
    always_comb begin
        ctrl_c = '0;
        case (state)
            ST_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.i_or_d    = 1'b0;
                ctrl_c.alu_src_a = 1'b0;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.pc_source = PCSRC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl_c.alu_src_a  = 1'b0;
                ctrl_c.alu_src_b  = SRCB_IMM_SH2;
                ctrl_c.alu_op     = ALU_ADD;
                ctrl_c.illegal_op = ~op_legal(opcode);
            end
            ST_R_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_RT;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                ctrl_c.reg_dst    = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b0;
                ctrl_c.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_c.reg_dst    = 1'b0;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.i_or_d     = 1'b1;
                ctrl_c.instr_done = mem_ready;
            end
            ST_BRANCH: begin
                ctrl_c.alu_src_a    = 1'b1;
                ctrl_c.alu_src_b    = SRCB_RT;
                ctrl_c.alu_op       = ALU_SUB;
                ctrl_c.pc_source    = PCSRC_ALUOUT;
                ctrl_c.pc_write_beq = (opcode == OP_BEQ);
                ctrl_c.pc_write_bne = (opcode == OP_BNE);
                ctrl_c.instr_done   = 1'b1;
            end
            ST_JUMP: begin
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.pc_source  = PCSRC_JUMP;
                ctrl_c.instr_done = 1'b1;
            end
            ST_I_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            ST_I_WB: begin
                ctrl_c.reg_dst    = 1'b0;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.alu_op     = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                ctrl_c.instr_done = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: Moore FSM stepping the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB with a memory ready handshake.
// Optional feature macro: MCC_PERF_CNT_EN adds retire/cycle counters (width CNT_W).
module multicycle_control
    import mips_pkg::*;
`ifdef MCC_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_beq,
    output logic            pc_write_bne,
    output logic [1:0]      pc_source,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            instr_done,
    output logic            illegal_op
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // State register; reset drops any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: opcode dispatch in DECODE, memory stalls hold their state
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:        state_d = ST_R_EXEC;
                    OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_d = ST_BRANCH;
                    OP_J:            state_d = ST_JUMP;
                    OP_ADDI, OP_ANDI: state_d = ST_I_EXEC;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_R_WB, ST_MEM_WB, ST_BRANCH,
            ST_JUMP, ST_I_WB: state_d = ST_FETCH;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output process: control word decoded from current state
    mcc_out_decode u_out_decode (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl_c    (ctrl)
    );

    assign pc_write     = ctrl.pc_write;
    assign pc_write_beq = ctrl.pc_write_beq;
    assign pc_write_bne = ctrl.pc_write_bne;
    assign pc_source    = ctrl.pc_source;
    assign i_or_d       = ctrl.i_or_d;
    assign mem_read     = ctrl.mem_read;
    assign mem_write    = ctrl.mem_write;
    assign ir_write     = ctrl.ir_write;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign reg_dst      = ctrl.reg_dst;
    assign reg_write    = ctrl.reg_write;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign alu_op       = ctrl.alu_op;
    assign instr_done   = ctrl.instr_done;
    assign illegal_op   = ctrl.illegal_op;

`ifdef MCC_PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter, both wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ctrl.instr_done) retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of per-cycle vectors plus
// hand-written reset, stall and (with MCC_PERF_CNT_EN) counter sequences.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        exp_t       exp;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, BAD = 6'b111111;

    // Expected control words, written out by hand from the behaviour description
    localparam exp_t E_IDLE    = '0;
    localparam exp_t E_F_WAIT  = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
    localparam exp_t E_F_GO    = '{mem_read:1'b1, alu_src_b:2'b01, ir_write:1'b1, pc_write:1'b1, default:'0};
    localparam exp_t E_DEC     = '{alu_src_b:2'b11, default:'0};
    localparam exp_t E_DEC_ILL = '{alu_src_b:2'b11, illegal_op:1'b1, default:'0};
    localparam exp_t E_R_EX    = '{alu_src_a:1'b1, alu_src_b:2'b00, alu_op:2'b10, default:'0};
    localparam exp_t E_R_WB    = '{reg_dst:1'b1, reg_write:1'b1, instr_done:1'b1, default:'0};
    localparam exp_t E_MADDR   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
    localparam exp_t E_MRD     = '{mem_read:1'b1, i_or_d:1'b1, default:'0};
    localparam exp_t E_MWB     = '{mem_to_reg:1'b1, reg_write:1'b1, instr_done:1'b1, default:'0};
    localparam exp_t E_MWR_W   = '{mem_write:1'b1, i_or_d:1'b1, default:'0};
    localparam exp_t E_MWR_GO  = '{mem_write:1'b1, i_or_d:1'b1, instr_done:1'b1, default:'0};
    localparam exp_t E_BEQ     = '{alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, pc_write_beq:1'b1, instr_done:1'b1, default:'0};
    localparam exp_t E_BNE     = '{alu_src_a:1'b1, alu_op:2'b01, pc_source:2'b01, pc_write_bne:1'b1, instr_done:1'b1, default:'0};
    localparam exp_t E_JMP     = '{pc_write:1'b1, pc_source:2'b10, instr_done:1'b1, default:'0};
    localparam exp_t E_ADDI_EX = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b00, default:'0};
    localparam exp_t E_ADDI_WB = '{reg_write:1'b1, instr_done:1'b1, alu_op:2'b00, default:'0};
    localparam exp_t E_ANDI_EX = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_op:2'b11, default:'0};
    localparam exp_t E_ANDI_WB = '{reg_write:1'b1, instr_done:1'b1, alu_op:2'b11, default:'0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
`ifdef MCC_PERF_CNT_EN
    logic [3:0] retire_cnt, cycle_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

`ifdef MCC_PERF_CNT_EN
    multicycle_control #(.CNT_W(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_beq (pc_write_beq),
        .pc_write_bne (pc_write_bne),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op),
        .retire_cnt   (retire_cnt),
        .cycle_cnt    (cycle_cnt)
    );
`else
    multicycle_control u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_beq (pc_write_beq),
        .pc_write_bne (pc_write_bne),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op)
    );
`endif

    function automatic exp_t actual();
        return {pc_write, pc_write_beq, pc_write_bne, pc_source, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, instr_done, illegal_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic [5:0] op, input logic mr, input exp_t e);
        vec_t v;
        v.op = op; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endtask

    // Apply inputs just after a falling edge, check, then advance one cycle
    task automatic step(input logic [5:0] op, input logic mr, input exp_t e, input string name);
        opcode = op;
        mem_ready = mr;
        #1;
        chk(name, 32'(actual()), 32'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(actual()), 32'(E_IDLE));
        rst_n = 1'b1;

        add(LW, 1, E_IDLE);
        add(LW, 1, E_F_GO); add(LW, 1, E_DEC); add(LW, 1, E_MADDR); add(LW, 1, E_MRD); add(LW, 1, E_MWB);
        add(SW, 1, E_F_GO); add(SW, 1, E_DEC); add(SW, 1, E_MADDR); add(SW, 0, E_MWR_W); add(SW, 1, E_MWR_GO);
        add(RT, 1, E_F_GO); add(RT, 1, E_DEC); add(RT, 1, E_R_EX); add(RT, 1, E_R_WB);
        add(BEQ, 1, E_F_GO); add(BEQ, 1, E_DEC); add(BEQ, 1, E_BEQ);
        add(BNE, 1, E_F_GO); add(BNE, 1, E_DEC); add(BNE, 1, E_BNE);
        add(JMP, 1, E_F_GO); add(JMP, 1, E_DEC); add(JMP, 1, E_JMP);
        add(ADDI, 1, E_F_GO); add(ADDI, 1, E_DEC); add(ADDI, 1, E_ADDI_EX); add(ADDI, 1, E_ADDI_WB);
        add(ANDI, 1, E_F_GO); add(ANDI, 1, E_DEC); add(ANDI, 1, E_ANDI_EX); add(ANDI, 1, E_ANDI_WB);
        add(BAD, 1, E_F_GO); add(BAD, 1, E_DEC_ILL);
        // back in FETCH after the illegal opcode, three stalled fetch cycles
        add(JMP, 0, E_F_WAIT); add(JMP, 0, E_F_WAIT); add(JMP, 0, E_F_WAIT);
        add(JMP, 1, E_F_GO); add(JMP, 1, E_DEC); add(JMP, 1, E_JMP);
        add(LW, 1, E_F_GO); add(LW, 1, E_DEC); add(LW, 1, E_MADDR); add(LW, 0, E_MRD); add(LW, 1, E_MRD); add(LW, 1, E_MWB);
        add(RT, 1, E_F_GO);

        foreach (vecs[i]) step(vecs[i].op, vecs[i].mr, vecs[i].exp, $sformatf("vec%0d", i));

        // Now in DECODE of an R-type; finish it, then reset in the middle of MEM_RD
        step(RT, 1, E_DEC, "rst_seq_dec");
        step(RT, 1, E_R_EX, "rst_seq_rex");
        step(RT, 1, E_R_WB, "rst_seq_rwb");
        step(LW, 1, E_F_GO, "rst_seq_fetch");
        step(LW, 1, E_DEC, "rst_seq_decode");
        step(LW, 1, E_MADDR, "rst_seq_maddr");
        opcode = LW;
        mem_ready = 1'b0;
        #1;
        chk("rst_seq_memrd", 32'(actual()), 32'(E_MRD));
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_async_zero", 32'(actual()), 32'(E_IDLE));
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_zero", 32'(actual()), 32'(E_IDLE));
        rst_n = 1'b1;
        step(LW, 0, E_IDLE, "post_rst_idle");
        step(LW, 0, E_F_WAIT, "post_rst_fetch");

`ifdef MCC_PERF_CNT_EN
        rst_n = 1'b0;
        @(negedge clk);
        chk("perf_rst_retire", 32'(retire_cnt), 32'd0);
        chk("perf_rst_cycle", 32'(cycle_cnt), 32'd0);
        rst_n = 1'b1;
        begin
            int ncyc = 0;
            step(JMP, 1, E_IDLE, "perf_idle");
            ncyc++;
            chk("perf_cycle", 32'(cycle_cnt), 32'(ncyc % 16));
            for (int k = 0; k < 20; k++) begin
                step(JMP, 1, E_F_GO, "perf_fetch");
                ncyc++;
                chk("perf_cycle", 32'(cycle_cnt), 32'(ncyc % 16));
                step(JMP, 1, E_DEC, "perf_decode");
                ncyc++;
                chk("perf_cycle", 32'(cycle_cnt), 32'(ncyc % 16));
                step(JMP, 1, E_JMP, "perf_jump");
                ncyc++;
                chk("perf_cycle", 32'(cycle_cnt), 32'(ncyc % 16));
            end
            chk("perf_retire_wrap", 32'(retire_cnt), 32'd4);
            chk("perf_cycle_final", 32'(cycle_cnt), 32'd13);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
